buffer_load_ctrl: RTL and testbench

Sequencer that fills the banked operand buffer and then drains it into the systolic array. On a start command it accepts a stream of 32-bit words, each holding two 16-bit elements. It issues one write per word to the buffer, to bank pair (addr, addr+1), then broadcasts a programmable number of shift cycles. It sits between the operand input stream and the buffer's data_in/addr/state port and reports busy/done to the top-level controller.

---
 rtl/buffer_load_ctrl.sv | 130 +++++++++++++
 tb/tb_buffer_load_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_load_ctrl.sv
// buffer_load_ctrl: fills the banked operand buffer two 16-bit banks per
// input word, then broadcasts a programmable number of shift cycles.
// All buf_* outputs and done are registered, so they trail the FSM state by
// one cycle.
module buffer_load_ctrl #(
  parameter int ARR_SIZE = 4,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        num_shifts,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic [31:0]       buf_data,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [1:0]        buf_state,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] BUF_HOLD  = 2'b00;
  localparam logic [1:0] BUF_WRITE = 2'b10;
  localparam logic [1:0] BUF_SHIFT = 2'b01;

  // Odd bank counts still take a full word on the last beat; the buffer
  // drops the upper half that would land beyond the last bank.
  localparam int                BEATS    = (ARR_SIZE + 1) / 2;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(2 * (BEATS - 1));

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        cnt;
  logic              start_ok;
  logic              beat;
  logic              last_beat;

  // The done pulse is registered, so in its cycle the state register already
  // reads IDLE; holding off start for that cycle keeps DONE->IDLE handoff
  // clean and a new command is taken only in the cycle after done.
  assign start_ok  = (state == IDLE) && start && !done;
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (ptr == LAST_PTR);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode plus the state-only handshake outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_n = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_beat) state_n = (cnt != 8'd0) ? SHIFT : DONE;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == 8'd1) state_n = DONE;
      end
      DONE: begin
        // Last cycle of the command seen from outside; done follows next.
        busy    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Write pointer, shift counter and registered buffer-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      cnt       <= 8'd0;
      buf_data  <= 32'd0;
      buf_addr  <= '0;
      buf_state <= BUF_HOLD;
      done      <= 1'b0;
    end else begin
      // Idle bus is all zeros so the buffer inputs never toggle needlessly.
      buf_data  <= 32'd0;
      buf_addr  <= '0;
      buf_state <= BUF_HOLD;
      done      <= (state == DONE);
      case (state)
        IDLE: begin
          if (start_ok) begin
            ptr <= '0;
            cnt <= num_shifts;
          end
        end
        LOAD: begin
          if (beat) begin
            buf_data  <= in_data;
            buf_addr  <= ptr;
            buf_state <= BUF_WRITE;
            // Pointer parks on the last pair so it never runs past the array.
            if (ptr != LAST_PTR) ptr <= ptr + ADDR_W'(2);
          end
        end
        SHIFT: begin
          buf_state <= BUF_SHIFT;
          cnt       <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_load_ctrl.sv
// Testbench for buffer_load_ctrl: one instance with 4 banks, one with 5.
// Expected buffer-port transactions and done pulses are queued as stimulus is
// driven and matched cycle-exactly when the DUT produces them.
module tb_buffer_load_ctrl;

  typedef struct {
    int          inst;
    int          cyc;
    logic [1:0]  st;
    logic [6:0]  addr;
    logic [31:0] data;
  } rec_t;

  typedef struct {
    int inst;
    int cyc;
  } dn_t;

  logic        clk;
  logic        rst;
  logic [1:0]  start;
  logic [1:0]  in_valid;
  logic [7:0]  num_shifts;
  logic [31:0] in_data;

  logic        in_ready4, busy4, done4;
  logic [31:0] buf_data4;
  logic [6:0]  buf_addr4;
  logic [1:0]  buf_state4;
  logic        in_ready5, busy5, done5;
  logic [31:0] buf_data5;
  logic [6:0]  buf_addr5;
  logic [1:0]  buf_state5;

  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  rec_t sb[$];
  dn_t  dq[$];

  buffer_load_ctrl #(.ARR_SIZE(4), .ADDR_W(7)) dut4 (
    .clk(clk), .rst(rst), .start(start[0]), .num_shifts(num_shifts),
    .in_valid(in_valid[0]), .in_data(in_data), .in_ready(in_ready4),
    .buf_data(buf_data4), .buf_addr(buf_addr4), .buf_state(buf_state4),
    .busy(busy4), .done(done4)
  );

  buffer_load_ctrl #(.ARR_SIZE(5), .ADDR_W(7)) dut5 (
    .clk(clk), .rst(rst), .start(start[1]), .num_shifts(num_shifts),
    .in_valid(in_valid[1]), .in_data(in_data), .in_ready(in_ready5),
    .buf_data(buf_data5), .buf_addr(buf_addr5), .buf_state(buf_state5),
    .busy(busy5), .done(done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic rdy(input int inst);
    return (inst == 0) ? in_ready4 : in_ready5;
  endfunction

  function automatic logic bsy(input int inst);
    return (inst == 0) ? busy4 : busy5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every active bus cycle and done pulse must match the head
  // of the scoreboard; an idle bus must carry zero address and data.
  task automatic mon(input int inst, input logic [1:0] st, input logic [6:0] a,
                     input logic [31:0] d, input logic dn);
    rec_t r;
    dn_t  e;
    if (st !== 2'b00) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL bus_inst%0d: got st=%b addr=%0d data=%h at cycle %0d, expected idle bus",
                 inst, st, a, d, cyc);
      end else begin
        r = sb.pop_front();
        if (r.inst != inst || r.cyc != cyc || r.st !== st || r.addr !== a || r.data !== d) begin
          n_err++;
          $display("FAIL bus_inst%0d: got st=%b addr=%0d data=%h cycle %0d, expected inst%0d st=%b addr=%0d data=%h cycle %0d",
                   inst, st, a, d, cyc, r.inst, r.st, r.addr, r.data, r.cyc);
        end
      end
    end else begin
      n_vec++;
      if (a !== 7'd0 || d !== 32'd0) begin
        n_err++;
        $display("FAIL hold_inst%0d: got addr=%0d data=%h at cycle %0d, expected zeros", inst, a, d, cyc);
      end
    end
    if (dn !== 1'b0) begin
      n_vec++;
      if (dq.size() == 0) begin
        n_err++;
        $display("FAIL done_inst%0d: got pulse at cycle %0d, expected none", inst, cyc);
      end else begin
        e = dq.pop_front();
        if (e.inst != inst || e.cyc != cyc) begin
          n_err++;
          $display("FAIL done_inst%0d: got pulse at cycle %0d, expected inst%0d cycle %0d",
                   inst, cyc, e.inst, e.cyc);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, buf_state4, buf_addr4, buf_data4, done4);
    mon(1, buf_state5, buf_addr5, buf_data5, done5);
  end

  // One full command on instance inst: queues the expected writes, shifts and
  // done pulse from the bench's own timing model and checks the handshake.
  // vpat bit k is in_valid for the k-th LOAD cycle; beyond npat it is 1.
  task automatic load_cmd(input int inst, input int arr, input int s,
                          input logic [7:0] vpat, input int npat,
                          input bit extra_valid, input bit start_in_shift,
                          input logic [15:0] base);
    int          beats;
    int          got;
    int          k;
    int          n_last;
    logic        v;
    logic        exp_b;
    logic [31:0] w;
    beats = (arr + 1) / 2;
    got   = 0;
    k     = 0;
    n_vec++;
    if (rdy(inst) !== 1'b0 || bsy(inst) !== 1'b0) begin
      n_err++;
      $display("FAIL idle_inst%0d: got ready=%b busy=%b at cycle %0d, expected 0 0",
               inst, rdy(inst), bsy(inst), cyc);
    end
    num_shifts  = 8'(s);
    start[inst] = 1'b1;
    tick();
    start[inst] = 1'b0;
    num_shifts  = 8'd9;
    while (got < beats) begin
      n_vec++;
      if (rdy(inst) !== 1'b1 || bsy(inst) !== 1'b1) begin
        n_err++;
        $display("FAIL load_inst%0d: got ready=%b busy=%b at cycle %0d, expected 1 1",
                 inst, rdy(inst), bsy(inst), cyc);
      end
      v = (k < npat) ? vpat[k] : 1'b1;
      w = {base + 16'(2 * got + 2), base + 16'(2 * got + 1)};
      in_valid[inst] = v;
      in_data        = v ? w : 32'hdead_beef;
      if (v) begin
        sb.push_back('{inst, cyc + 1, 2'b10, 7'(2 * got), w});
        got++;
      end
      k++;
      tick();
    end
    n_last         = cyc - 1;
    in_valid[inst] = extra_valid;
    in_data        = 32'hbad0_bad0;
    for (int j = 0; j < s; j++) sb.push_back('{inst, n_last + 2 + j, 2'b01, 7'd0, 32'd0});
    dq.push_back('{inst, n_last + 2 + s});
    while (cyc <= n_last + 2 + s) begin
      exp_b = (cyc <= n_last + 1 + s);
      n_vec++;
      if (rdy(inst) !== 1'b0 || bsy(inst) !== exp_b) begin
        n_err++;
        $display("FAIL tail_inst%0d: got ready=%b busy=%b at cycle %0d, expected 0 %b",
                 inst, rdy(inst), bsy(inst), cyc, exp_b);
      end
      start[inst] = start_in_shift && (cyc == n_last + 2);
      tick();
    end
    start[inst]    = 1'b0;
    in_valid[inst] = 1'b0;
    n_vec++;
    if (sb.size() != 0 || dq.size() != 0) begin
      n_err++;
      $display("FAIL pending_inst%0d: got %0d bus and %0d done items outstanding, expected 0 0",
               inst, sb.size(), dq.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_vec++;
    if ({in_ready4, busy4, done4, buf_state4, buf_addr4, buf_data4} !== '0 ||
        {in_ready5, busy5, done5, buf_state5, buf_addr5, buf_data5} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got inst0 %b%b%b %b %0d %h inst1 %b%b%b %b %0d %h, expected all zero",
               in_ready4, busy4, done4, buf_state4, buf_addr4, buf_data4,
               in_ready5, busy5, done5, buf_state5, buf_addr5, buf_data5);
    end
    rst = 1'b0;
    tick();
  endtask

  // Four banks, S=3, two back-to-back words: done lands 7 cycles after start.
  task automatic test_basic();
    load_cmd(0, 4, 3, 8'h00, 0, 1'b0, 1'b0, 16'h0000);
  endtask

  // Five banks, S=1: three beats at 0,2,4; a fourth valid word stays unaccepted.
  task automatic test_odd_arr();
    load_cmd(1, 5, 1, 8'h00, 0, 1'b1, 1'b0, 16'h1000);
  endtask

  // in_valid 1,0,0,1: gaps stall LOAD with an idle bus, pointer moves on beats only.
  task automatic test_backpressure();
    load_cmd(0, 4, 2, 8'b0000_1001, 4, 1'b0, 1'b0, 16'h2000);
  endtask

  // S=0: straight from the last write to done, never a shift cycle.
  task automatic test_zero_shift();
    load_cmd(1, 5, 0, 8'b0000_0101, 3, 1'b0, 1'b0, 16'h3000);
    load_cmd(0, 4, 0, 8'h00, 0, 1'b0, 1'b0, 16'h3100);
  endtask

  // Reset in the second LOAD cycle: outputs clear next cycle, no done pulse,
  // and the following command restarts at bank 0.
  task automatic test_rst_mid_load();
    logic [31:0] w;
    w = 32'h1111_2222;
    num_shifts = 8'd2;
    start[0]   = 1'b1;
    tick();
    start[0]    = 1'b0;
    in_valid[0] = 1'b1;
    in_data     = w;
    sb.push_back('{0, cyc + 1, 2'b10, 7'd0, w});
    tick();
    in_data = 32'h3333_4444;
    rst     = 1'b1;
    tick();
    rst         = 1'b0;
    in_valid[0] = 1'b0;
    n_vec++;
    if ({in_ready4, busy4, done4, buf_state4, buf_addr4, buf_data4} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_load: got ready=%b busy=%b done=%b st=%b addr=%0d data=%h, expected all zero",
               in_ready4, busy4, done4, buf_state4, buf_addr4, buf_data4);
    end
    repeat (4) tick();
    n_vec++;
    if (busy4 !== 1'b0 || sb.size() != 0 || dq.size() != 0) begin
      n_err++;
      $display("FAIL rst_quiet: got busy=%b bus_items=%0d done_items=%0d, expected 0 0 0",
               busy4, sb.size(), dq.size());
    end
    load_cmd(0, 4, 1, 8'h00, 0, 1'b0, 1'b0, 16'h4000);
  endtask

  // start with num_shifts=9 during SHIFT is ignored; S=3 completes, one done.
  task automatic test_start_in_shift();
    load_cmd(0, 4, 3, 8'h00, 0, 1'b0, 1'b1, 16'h5000);
    repeat (3) tick();
    n_vec++;
    if (busy4 !== 1'b0 || dq.size() != 0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL start_in_shift: got busy=%b bus_items=%0d done_items=%0d, expected 0 0 0",
               busy4, sb.size(), dq.size());
    end
  endtask

  // Commands issued in the cycle right after done, on both bank counts.
  task automatic test_back_to_back();
    load_cmd(1, 5, 2, 8'h00, 0, 1'b0, 1'b0, 16'h6000);
    load_cmd(1, 5, 1, 8'b0000_0010, 2, 1'b0, 1'b0, 16'h6100);
    load_cmd(0, 4, 4, 8'h00, 0, 1'b0, 1'b0, 16'h6200);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 2'b00;
    in_valid   = 2'b00;
    num_shifts = 8'd0;
    in_data    = 32'd0;
    test_reset();
    test_basic();
    test_odd_arr();
    test_backpressure();
    test_zero_shift();
    test_rst_mid_load();
    test_start_in_shift();
    test_back_to_back();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
